// File: rtl/adder_arbiter.sv
// ---------------------------------------------------------------------------
// eight_bit_adder
//   Combinational 8-bit adder/subtractor shared by the arbiter below.
//   Ports:
//     A, B      in   8   signed operands
//     Opcode    in   1   0 = A+B, 1 = A-B (A + ~B + 1)
//     Sum       out  8   signed result
//     Carry     out  1   carry-out of the 8-bit addition
//     Overflow  out  1   signed overflow
// ---------------------------------------------------------------------------
module eight_bit_adder (
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic       Opcode,
   output logic [7:0] Sum,
   output logic       Carry,
   output logic       Overflow
);

   logic [7:0] b_eff;
   logic [8:0] full;

   always_comb begin
      b_eff = Opcode ? ~B : B;
      // Subtraction is A + ~B + 1, so Opcode doubles as the carry-in.
      full  = {1'b0, A} + {1'b0, b_eff} + {8'd0, Opcode};
   end

   assign Sum      = full[7:0];
   assign Carry    = full[8];
   // Overflow when both effective operands share a sign the result lacks.
   assign Overflow = (A[7] == b_eff[7]) && (full[7] != A[7]);

endmodule

// ---------------------------------------------------------------------------
// adder_arbiter
//   Shares one eight_bit_adder between two requesters with round-robin
//   arbitration. Operands are latched on the request handshake, the result is
//   registered and held on a shared response bus until the consumer takes it.
//   Ports:
//     clk, rstn                   clock (rising edge), async active-low reset
//     reqN_valid / reqN_ready     request handshake, N = 0,1
//     reqN_a, reqN_b, reqN_op     operands and opcode (0 = add, 1 = sub)
//     rsp_valid / rsp_ready       response handshake
//     rsp_id                      requester that issued the response
//     rsp_sum, rsp_carry, rsp_ovf registered adder results
//     busy                        high whenever the FSM is not idle
//     op_count                    completed operations, wraps at 16 bits
// ---------------------------------------------------------------------------
module adder_arbiter #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned START_PRIO = 0
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic              req0_op,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic              req1_op,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_sum,
   output logic              rsp_carry,
   output logic              rsp_ovf,
   output logic              busy,
   output logic [15:0]       op_count
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   // Reset value of last_grant makes START_PRIO win the first contention.
   localparam logic LastGrantRst = (START_PRIO != 0) ? 1'b0 : 1'b1;

   state_e            state_q;
   logic              last_grant_q;
   logic [DATA_W-1:0] lat_a_q;
   logic [DATA_W-1:0] lat_b_q;
   logic              lat_op_q;
   logic              lat_id_q;

   logic              grant0;
   logic              grant1;
   logic [DATA_W-1:0] add_sum;
   logic              add_carry;
   logic              add_ovf;

   eight_bit_adder u_adder (
      .A        (lat_a_q),
      .B        (lat_b_q),
      .Opcode   (lat_op_q),
      .Sum      (add_sum),
      .Carry    (add_carry),
      .Overflow (add_ovf)
   );

   // Combinational grant, only offered while idle and out of reset.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (rstn && (state_q == StIdle)) begin
         if (req0_valid && req1_valid) begin
            if (last_grant_q) grant0 = 1'b1;
            else              grant1 = 1'b1;
         end else if (req0_valid) begin
            grant0 = 1'b1;
         end else if (req1_valid) begin
            grant1 = 1'b1;
         end
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign busy       = (state_q != StIdle);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= StIdle;
         last_grant_q <= LastGrantRst;
         lat_a_q      <= '0;
         lat_b_q      <= '0;
         lat_op_q     <= 1'b0;
         lat_id_q     <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_id       <= 1'b0;
         rsp_sum      <= '0;
         rsp_carry    <= 1'b0;
         rsp_ovf      <= 1'b0;
         op_count     <= 16'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (grant0 || grant1) begin
                  lat_a_q      <= grant1 ? req1_a  : req0_a;
                  lat_b_q      <= grant1 ? req1_b  : req0_b;
                  lat_op_q     <= grant1 ? req1_op : req0_op;
                  lat_id_q     <= grant1;
                  last_grant_q <= grant1;
                  state_q      <= StExec;
               end
            end
            StExec: begin
               rsp_sum   <= add_sum;
               rsp_carry <= add_carry;
               rsp_ovf   <= add_ovf;
               rsp_id    <= lat_id_q;
               rsp_valid <= 1'b1;
               state_q   <= StResp;
            end
            StResp: begin
               // Response fields stay untouched until the consumer takes them.
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  op_count  <= op_count + 16'd1;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;

   logic       clk = 1'b0;
   logic       rstn;
   logic       req0_valid, req0_ready, req0_op;
   logic [7:0] req0_a, req0_b;
   logic       req1_valid, req1_ready, req1_op;
   logic [7:0] req1_a, req1_b;
   logic       rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_ovf, busy;
   logic [7:0] rsp_sum;
   logic [15:0] op_count;

   always #5 clk = ~clk;

   adder_arbiter #(.DATA_W(8), .START_PRIO(0)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_op    (req0_op),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_op    (req1_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_sum    (rsp_sum),
      .rsp_carry  (rsp_carry),
      .rsp_ovf    (rsp_ovf),
      .busy       (busy),
      .op_count   (op_count)
   );

   typedef struct packed {
      logic       id;
      logic [7:0] sum;
      logic       carry;
      logic       ovf;
   } rsp_t;

   rsp_t exp_q[$];
   rsp_t exp_e;
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_rsp = 0;
   logic both_ready = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: pops an expectation on every response handshake.
   always @(negedge clk) begin
      if (req0_ready && req1_ready) both_ready = 1'b1;
      if (rstn && rsp_valid && rsp_ready) begin
         n_rsp++;
         if (exp_q.size() == 0) begin
            check("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            exp_e = exp_q.pop_front();
            check("rsp_id", rsp_id, exp_e.id);
            check("rsp_sum", rsp_sum, exp_e.sum);
            check("rsp_carry", rsp_carry, exp_e.carry);
            check("rsp_ovf", rsp_ovf, exp_e.ovf);
         end
      end
   end

   task automatic drive_req(input logic r, input logic v, input logic [7:0] a,
                            input logic [7:0] b, input logic op);
      if (r == 1'b0) begin
         req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
      end else begin
         req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
      end
   endtask

   task automatic wait_ready(input logic r, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if ((r == 1'b0 && req0_ready) || (r == 1'b1 && req1_ready)) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_rsp(input int target);
      for (int i = 0; i < 40; i++) begin
         if (n_rsp >= target) break;
         @(negedge clk);
      end
      if (n_rsp < target) check("rsp_timeout", n_rsp, target);
   endtask

   task automatic apply_reset();
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
   endtask

   // Single op with rsp_ready high; checks the two-cycle response latency.
   task automatic do_op(input logic r, input logic [7:0] a, input logic [7:0] b,
                        input logic op, input logic [7:0] s, input logic c, input logic o);
      logic ok;
      exp_q.push_back({r, s, c, o});
      @(posedge clk);
      #1 drive_req(r, 1'b1, a, b, op);
      wait_ready(r, ok);
      if (!ok) begin
         drive_req(r, 1'b0, 8'h00, 8'h00, 1'b0);
         void'(exp_q.pop_back());
         return;
      end
      @(posedge clk);
      #1 drive_req(r, 1'b0, 8'hEE, 8'hEE, ~op);  // latched copy must be used
      @(negedge clk);
      check("lat_exec_valid", rsp_valid, 1'b0);
      check("lat_exec_busy", busy, 1'b1);
      @(negedge clk);
      check("lat_resp_valid", rsp_valid, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic ok;
      int   grants;
      int   base;

      rstn = 1'b0;
      rsp_ready = 1'b1;
      drive_req(1'b0, 1'b1, 8'd1, 8'd1, 1'b0);
      drive_req(1'b1, 1'b1, 8'd1, 8'd1, 1'b0);
      #3;
      // Reset state, including ready forced low with both valids high.
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_op_count", op_count, 16'd0);
      check("rst_rsp_sum", rsp_sum, 8'd0);
      check("rst_ready0", req0_ready, 1'b0);
      check("rst_ready1", req1_ready, 1'b0);
      drive_req(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
      drive_req(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
      apply_reset();

      // 1-3) directed arithmetic vectors
      do_op(1'b0, 8'd50, 8'd60, 1'b0, 8'd110, 1'b0, 1'b0);
      do_op(1'b1, 8'd100, 8'd100, 1'b0, 8'hC8, 1'b0, 1'b1);
      do_op(1'b1, 8'h85, 8'hFA, 1'b0, 8'h7F, 1'b1, 1'b1);
      do_op(1'b0, 8'd10, 8'h83, 1'b1, 8'h87, 1'b0, 1'b1);
      do_op(1'b0, 8'd5, 8'd6, 1'b1, 8'hFF, 1'b0, 1'b0);
      @(negedge clk);
      check("op_count_5", op_count, 16'd5);
      check("idle_after_ops", busy, 1'b0);

      // 4) continuous contention alternates 0,1,0,1 from START_PRIO
      apply_reset();
      check("op_count_cleared", op_count, 16'd0);
      base = n_rsp;
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back({1'b0, 8'd3, 1'b0, 1'b0});   // 1 + 2
         exp_q.push_back({1'b1, 8'd4, 1'b1, 1'b0});   // 7 - 3
      end
      @(posedge clk);
      #1;
      drive_req(1'b0, 1'b1, 8'd1, 8'd2, 1'b0);
      drive_req(1'b1, 1'b1, 8'd7, 8'd3, 1'b1);
      grants = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (req0_ready || req1_ready) begin
            grants++;
            if (grants == 4) begin
               @(posedge clk);
               #1;
               drive_req(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
               drive_req(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
               break;
            end
         end
      end
      check("grants_4", grants, 4);
      wait_rsp(base + 4);
      @(negedge clk);
      check("op_count_4", op_count, 16'd4);
      check("never_both_ready", both_ready, 1'b0);

      // 5) backpressure: response held stable, no grant while stalled
      rsp_ready = 1'b0;
      exp_q.push_back({1'b1, 8'd50, 1'b0, 1'b0});
      @(posedge clk);
      #1 drive_req(1'b1, 1'b1, 8'd20, 8'd30, 1'b0);
      wait_ready(1'b1, ok);
      @(posedge clk);
      #1;
      drive_req(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
      drive_req(1'b0, 1'b1, 8'd1, 8'd1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid) break;
      end
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", rsp_valid, 1'b1);
         check("stall_sum", rsp_sum, 8'd50);
         check("stall_id", rsp_id, 1'b1);
         check("stall_busy", busy, 1'b1);
         check("stall_ready0", req0_ready, 1'b0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      drive_req(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
      rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("idle_after_release", busy, 1'b0);
      check("op_count_5b", op_count, 16'd5);

      // 6) reset during EXEC drops the op; START_PRIO wins afterwards
      @(posedge clk);
      #1;
      drive_req(1'b0, 1'b1, 8'd9, 8'd9, 1'b0);
      drive_req(1'b1, 1'b1, 8'd4, 8'd4, 1'b0);
      wait_ready(1'b0, ok);
      @(posedge clk);
      #1 rstn = 1'b0;
      #1;
      check("mid_rst_valid", rsp_valid, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_count", op_count, 16'd0);
      check("mid_rst_ready0", req0_ready, 1'b0);
      check("mid_rst_ready1", req1_ready, 1'b0);
      @(posedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
      check("post_rst_ready0", req0_ready, 1'b1);
      check("post_rst_ready1", req1_ready, 1'b0);
      base = n_rsp;
      exp_q.push_back({1'b0, 8'd18, 1'b0, 1'b0});
      @(posedge clk);
      #1;
      drive_req(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
      drive_req(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
      wait_rsp(base + 1);
      repeat (4) @(negedge clk);
      check("rsp_after_rst", n_rsp, base + 1);
      check("queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
